// File: rtl/ifetch_mem_responder.sv
// Instruction-side memory responder: accepts one fetch address at a time and returns
// the stored word with a one-cycle data_already strobe after LATENCY cycles.
module ifetch_mem_responder #(
  parameter int unsigned  DEPTH_WORDS = 1024,
  parameter int unsigned  LATENCY     = 2,
  parameter logic [31:0]  NOP_WORD    = 32'h0000_0013,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   addr_in,
  input  logic          addr_valid,
  input  logic          mau_busy,
  output logic [31:0]   data_out,
  output logic          data_already,
  output logic          addr_err,
  output logic          req_ready,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // WAIT holds LATENCY-1 unstalled cycles; a single-cycle latency skips WAIT entirely.
  localparam logic [3:0] WAIT_LOAD    = 4'(LATENCY - 32'd1);
  localparam bit         SINGLE_CYCLE = (LATENCY == 32'd1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic          stb_q, stb_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept_s;
  logic          enter_resp_s;
  logic [31:0]   rd_addr_s;
  logic [29:0]   rd_idx_s;
  logic          rd_oob_s;
  logic          rd_mis_s;

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign accept_s  = req_ready && addr_valid && !mau_busy;

  // RESP is entered from WAIT (latched address) or directly on a single-cycle accept.
  assign rd_addr_s = (state_q == WAIT) ? addr_q : addr_in;
  assign rd_idx_s  = rd_addr_s[31:2];
  assign rd_oob_s  = ({2'b00, rd_idx_s} >= DEPTH_WORDS);
  assign rd_mis_s  = (rd_addr_s[1:0] != 2'b00);

  // Next-state logic for the request handshake and latency counter.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    enter_resp_s = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (accept_s) begin
          addr_d = addr_in;
          if (SINGLE_CYCLE) begin
            state_d      = RESP;
            cnt_d        = 4'd0;
            enter_resp_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mau_busy) begin
          state_d = WAIT;
        end else if (cnt_q <= 4'd1) begin
          state_d      = RESP;
          cnt_d        = 4'd0;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response word and error flag, captured on the edge that enters RESP.
  always_comb begin
    data_d = data_q;
    err_d  = 1'b0;
    stb_d  = enter_resp_s;
    if (enter_resp_s) begin
      data_d = rd_oob_s ? NOP_WORD : mem_q[rd_idx_s[AW-1:0]];
      err_d  = rd_oob_s || rd_mis_s;
    end else begin
      err_d  = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      stb_q   <= stb_d;
    end
  end

  // Program-load port; deliberately outside reset so loads work while reset is held.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign data_out     = data_q;
  assign data_already = stb_q;
  assign addr_err     = err_q;

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Randomized bench: three responders (LATENCY 1, 2, 3) share the load port and mau_busy,
// each checked every cycle against a deadline-based reference model.
module tb_ifetch_mem_responder;

  localparam int unsigned NI  = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        mau_busy;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        av   [NI];
  logic [31:0] ain  [NI];
  logic [31:0] dout [NI];
  logic        stb  [NI];
  logic        err  [NI];
  logic        rdy  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ifetch_mem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY    (g + 1),
      .NOP_WORD   (NOP)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .addr_in     (ain[g]),
      .addr_valid  (av[g]),
      .mau_busy    (mau_busy),
      .data_out    (dout[g]),
      .data_already(stb[g]),
      .addr_err    (err[g]),
      .req_ready   (rdy[g]),
      .load_we     (load_we),
      .load_addr   (load_addr),
      .load_data   (load_data)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // Reference model: pending request with an absolute deadline cycle.
  int unsigned cyc = 0;
  bit          waiting  [NI];
  int unsigned due      [NI];
  logic [31:0] maddr    [NI];
  bit          exp_stb  [NI];
  logic [31:0] exp_dout [NI];
  bit          exp_err  [NI];
  logic [31:0] mem_m    [1024];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [32:0] ref_fetch(input logic [31:0] a);
    if (a[31:2] >= 30'd1024) return {1'b1, NOP};
    return {(a[1:0] != 2'b00), mem_m[a[11:2]]};
  endfunction

  function automatic logic [31:0] gen_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0)      return 32'h0000_1000 + ($urandom & 32'h0FFF_FFFF);
    else if (k == 1) return 32'(($urandom_range(0, 15) << 2) | $urandom_range(1, 3));
    else if (k == 2) return 32'hFFFF_FFFC;
    else             return 32'($urandom_range(0, 15) << 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      waiting[i]  = 1'b0;
      exp_stb[i]  = 1'b0;
      exp_dout[i] = 32'd0;
      exp_err[i]  = 1'b0;
    end
  endtask

  // Effect of the coming posedge, given the inputs just driven.
  task automatic model_step();
    logic [32:0] r;
    for (int i = 0; i < NI; i++) begin
      bit ready;
      bit s;
      ready = !waiting[i];
      s     = 1'b0;
      if (waiting[i] && mau_busy) due[i]++;
      if (ready && av[i] && !mau_busy) begin
        waiting[i] = 1'b1;
        due[i]     = cyc + i + 1;
        maddr[i]   = ain[i];
      end
      if (waiting[i] && due[i] == cyc + 1) begin
        waiting[i]  = 1'b0;
        s           = 1'b1;
        r           = ref_fetch(maddr[i]);
        exp_err[i]  = r[32];
        exp_dout[i] = r[31:0];
      end
      exp_stb[i] = s;
    end
    if (load_we) mem_m[load_addr] = load_data;
    cyc++;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("strobe[L%0d]", i + 1), 32'(stb[i]), 32'(exp_stb[i]));
      check_eq($sformatf("req_ready[L%0d]", i + 1), 32'(rdy[i]), 32'(!waiting[i]));
      check_eq($sformatf("data_out[L%0d]", i + 1), dout[i], exp_dout[i]);
      check_eq($sformatf("addr_err[L%0d]", i + 1), 32'(err[i]), exp_stb[i] ? 32'(exp_err[i]) : 32'd0);
    end
  endtask

  task automatic drive_random();
    mau_busy  = ($urandom_range(0, 3) == 0);
    load_we   = ($urandom_range(0, 4) == 0);
    load_addr = 10'($urandom_range(0, 15));
    load_data = $urandom;
    for (int i = 0; i < NI; i++) begin
      av[i]  = ($urandom_range(0, 3) != 0);
      ain[i] = gen_addr();
    end
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      check_outputs();
      drive_random();
      model_step();
      @(negedge clk);
    end
  endtask

  initial begin
    int budget;
    reset     = 1'b0;
    mau_busy  = 1'b0;
    load_we   = 1'b0;
    load_addr = 10'd0;
    load_data = 32'd0;
    for (int i = 0; i < NI; i++) begin
      av[i]  = 1'b0;
      ain[i] = 32'd0;
    end
    model_reset();

    // Preload while reset is held; writes must not be blocked by reset.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      load_we   = 1'b1;
      load_addr = 10'(k);
      load_data = $urandom;
      mem_m[k]  = load_data;
    end
    @(negedge clk);
    load_we = 1'b0;
    reset   = 1'b1;

    run_cycles(600);

    // Assert reset in the middle of a LATENCY=3 wait.
    budget = 200;
    while (!waiting[2] && budget > 0) begin
      run_cycles(1);
      budget--;
    end
    check_eq("mid_wait_reached", 32'(waiting[2]), 32'd1);
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("rst_strobe[L%0d]", i + 1), 32'(stb[i]), 32'd0);
      check_eq($sformatf("rst_data[L%0d]", i + 1), dout[i], 32'd0);
      check_eq($sformatf("rst_err[L%0d]", i + 1), 32'(err[i]), 32'd0);
    end
    model_reset();
    #1 reset = 1'b1;

    run_cycles(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
